geofence_feeder: RTL

Point-stream source and result collector for the `geofence` evaluator. Accepts rounds of seven 10-bit coordinate pairs from an upstream handshake into a ping-pong buffer. Replays each round onto the evaluator's `X`/`Y` bus on consecutive cycles, with a `dut_reset` pulse framing each round. Captures `valid`/`is_inside` and returns a tagged result over a ready/valid handshake, with a timeout guard.

---
 rtl/geofence_feeder.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/geofence_feeder.sv
// geofence_feeder: buffers 7-point rounds in a ping-pong RAM, replays each round to the
// geofence evaluator framed by dut_reset, and returns a tagged inside/timeout result.
module geofence_feeder #(
  parameter int TIMEOUT = 1023
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [9:0] in_x,
  input  logic [9:0] in_y,
  output logic [9:0] X,
  output logic [9:0] Y,
  output logic       dut_reset,
  input  logic       valid,
  input  logic       is_inside,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       res_inside,
  output logic       res_timeout,
  output logic [7:0] res_round
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, REPORT} state_t;

  localparam logic [2:0] LAST_IDX = 3'd6;
  localparam logic [9:0] TO_LAST  = 10'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [1:0]  full_q, full_d, full_set, full_clr;
  logic        wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [2:0]  wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic        dut_reset_q, dut_reset_d;
  logic        res_valid_q, res_valid_d;
  logic        res_inside_q, res_inside_d;
  logic        res_timeout_q, res_timeout_d;
  logic [7:0]  res_round_q, res_round_d;
  logic        wr_en;
  logic [19:0] rd_word;

  // Address is {bank, idx}; entries 7 and 15 are never used.
  logic [19:0] buf_mem [0:15];

  assign in_ready = ~full_q[wr_bank_q];
  assign wr_en    = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      buf_mem[{wr_bank_q, wr_idx_q}] <= {in_x, in_y};
    end
  end

  always_comb begin
    wr_idx_d  = wr_idx_q;
    wr_bank_d = wr_bank_q;
    full_set  = '0;
    if (wr_en) begin
      if (wr_idx_q == LAST_IDX) begin
        wr_idx_d            = '0;
        wr_bank_d           = ~wr_bank_q;
        full_set[wr_bank_q] = 1'b1;
      end else begin
        wr_idx_d = wr_idx_q + 3'd1;
      end
    end
  end

  // Outputs are registered, so they are derived from the next state and next read index.
  always_comb begin
    state_d       = state_q;
    rd_idx_d      = rd_idx_q;
    rd_bank_d     = rd_bank_q;
    cnt_d         = cnt_q;
    full_clr      = '0;
    res_inside_d  = res_inside_q;
    res_timeout_d = res_timeout_q;
    res_round_d   = res_round_q;
    case (state_q)
      IDLE: begin
        if (full_q[rd_bank_q]) begin
          state_d  = SEND;
          rd_idx_d = '0;
        end
      end
      SEND: begin
        if (rd_idx_q == LAST_IDX) begin
          full_clr[rd_bank_q] = 1'b1;
          rd_bank_d           = ~rd_bank_q;
          rd_idx_d            = '0;
          cnt_d               = '0;
          state_d             = WAIT;
        end else begin
          rd_idx_d = rd_idx_q + 3'd1;
        end
      end
      WAIT: begin
        if (valid) begin
          res_inside_d  = is_inside;
          res_timeout_d = 1'b0;
          state_d       = REPORT;
        end else if (cnt_q == TO_LAST) begin
          res_inside_d  = 1'b0;
          res_timeout_d = 1'b1;
          state_d       = REPORT;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      REPORT: begin
        if (res_ready) begin
          res_round_d = res_round_q + 8'd1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    rd_word     = buf_mem[{rd_bank_d, rd_idx_d}];
    x_d         = (state_d == SEND) ? rd_word[19:10] : '0;
    y_d         = (state_d == SEND) ? rd_word[9:0]   : '0;
    dut_reset_d = (state_d == IDLE) || (state_d == REPORT);
    res_valid_d = (state_d == REPORT);
  end

  assign full_d = (full_q | full_set) & ~full_clr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      full_q        <= '0;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      wr_idx_q      <= '0;
      rd_idx_q      <= '0;
      cnt_q         <= '0;
      x_q           <= '0;
      y_q           <= '0;
      dut_reset_q   <= 1'b1;
      res_valid_q   <= 1'b0;
      res_inside_q  <= 1'b0;
      res_timeout_q <= 1'b0;
      res_round_q   <= '0;
    end else begin
      state_q       <= state_d;
      full_q        <= full_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      wr_idx_q      <= wr_idx_d;
      rd_idx_q      <= rd_idx_d;
      cnt_q         <= cnt_d;
      x_q           <= x_d;
      y_q           <= y_d;
      dut_reset_q   <= dut_reset_d;
      res_valid_q   <= res_valid_d;
      res_inside_q  <= res_inside_d;
      res_timeout_q <= res_timeout_d;
      res_round_q   <= res_round_d;
    end
  end

  assign X           = x_q;
  assign Y           = y_q;
  assign dut_reset   = dut_reset_q;
  assign res_valid   = res_valid_q;
  assign res_inside  = res_inside_q;
  assign res_timeout = res_timeout_q;
  assign res_round   = res_round_q;

endmodule
